// File: rtl/rp_reconfig_ctrl.sv
// Shutdown/drain/decouple/reset/release sequencer for the
// reconfigurable partition carrying the ETH, DMA and PCIe datapaths.
module rp_reconfig_ctrl #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int DRAIN_TIMEOUT   = 65535,
  parameter int RESET_HOLD      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pr_start,
  input  logic       pr_done,
  output logic       rp_shutdown_req,
  input  logic       rp_shutdown_ack,
  input  logic       rp_active,
  output logic       rp_rst_n,
  output logic       decouple,
  output logic       block_axi,
  input  logic       ar_hs,
  input  logic       r_last_hs,
  input  logic       aw_hs,
  input  logic       b_hs,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overflow,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int HW = $clog2(RESET_HOLD + 1);

  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
  localparam logic [31:0] TMO_LAST = 32'(DRAIN_TIMEOUT - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_REQ     = 3'd1,
    S_DRAIN   = 3'd2,
    S_WAIT_PR = 3'd3,
    S_RESET   = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [31:0]     timer;
  logic [HW-1:0]   hold;
  logic [CW-1:0]   rd_cnt;
  logic [CW-1:0]   wr_cnt;
  logic            drain_ok;
  logic            tmo;
  logic            cnt_en;
  logic            req_entry;
  logic            rst_n_d;
  logic            dec_d;
  logic            blk_d;
  logic            req_d;
  logic [CW:0]     rd_step;
  logic [CW:0]     wr_step;

  // Returns {error, next_count}; a simultaneous inc/dec is a no-op.
  function automatic logic [CW:0] cnt_step(
    input logic [CW-1:0] c,
    input logic          inc,
    input logic          dec
  );
    logic [CW-1:0] n;
    logic          e;
    n = c;
    e = 1'b0;
    if (inc && !dec) begin
      if (c == CMAX) e = 1'b1;
      else n = c + CW'(1);
    end else if (dec && !inc) begin
      if (c == '0) e = 1'b1;
      else n = c - CW'(1);
    end
    return {e, n};
  endfunction

  assign drain_ok  = rp_shutdown_ack && (rd_cnt == '0)
                     && (wr_cnt == '0);
  assign tmo       = (timer == TMO_LAST);
  assign cnt_en    = (state != S_WAIT_PR) && (state != S_RESET);
  assign req_entry = (state == S_RUN) && (nxt == S_REQ);
  assign rd_step   = cnt_step(rd_cnt, ar_hs, r_last_hs);
  assign wr_step   = cnt_step(wr_cnt, aw_hs, b_hs);

  always_comb begin
    nxt     = state;
    rst_n_d = 1'b1;
    dec_d   = 1'b1;
    blk_d   = 1'b1;
    req_d   = 1'b0;
    unique case (state)
      S_RUN:     if (pr_start) nxt = S_REQ;
      S_REQ:     nxt = S_DRAIN;
      S_DRAIN:   if (drain_ok || tmo) nxt = S_WAIT_PR;
      S_WAIT_PR: if (pr_done) nxt = S_RESET;
      S_RESET:   if (hold <= HW'(1)) nxt = S_RELEASE;
      S_RELEASE: if (rp_active) nxt = S_RUN;
      default:   nxt = S_RESET;
    endcase
    // Outputs are registered, so decode from the state being entered.
    unique case (nxt)
      S_RUN: begin
        dec_d = 1'b0;
        blk_d = 1'b0;
      end
      S_REQ, S_DRAIN: begin
        dec_d = 1'b0;
        req_d = 1'b1;
      end
      S_WAIT_PR: req_d = 1'b1;
      S_RESET:   rst_n_d = 1'b0;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_RESET;
      timer           <= '0;
      hold            <= HOLD_INIT;
      rd_cnt          <= '0;
      wr_cnt          <= '0;
      err_timeout     <= 1'b0;
      err_overflow    <= 1'b0;
      rp_shutdown_req <= 1'b0;
      rp_rst_n        <= 1'b0;
      decouple        <= 1'b1;
      block_axi       <= 1'b1;
      busy            <= 1'b1;
      state_o         <= 3'd4;
    end else begin
      state           <= nxt;
      state_o         <= nxt;
      busy            <= (nxt != S_RUN);
      rp_rst_n        <= rst_n_d;
      decouple        <= dec_d;
      block_axi       <= blk_d;
      rp_shutdown_req <= req_d;

      if (req_entry) timer <= '0;
      else if (state == S_DRAIN) timer <= timer + 32'd1;

      if (state == S_WAIT_PR && nxt == S_RESET) hold <= HOLD_INIT;
      else if (state == S_RESET && hold != '0) hold <= hold - HW'(1);

      // In-flight beats are abandoned once the boundary is decoupled.
      if (nxt == S_WAIT_PR && state != S_WAIT_PR) begin
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else if (cnt_en) begin
        rd_cnt <= rd_step[CW-1:0];
        wr_cnt <= wr_step[CW-1:0];
        if (rd_step[CW] || wr_step[CW]) err_overflow <= 1'b1;
      end

      if (state == S_DRAIN && tmo && !drain_ok) err_timeout <= 1'b1;

      if (req_entry) begin
        err_timeout  <= 1'b0;
        err_overflow <= 1'b0;
      end
    end
  end

endmodule
